// File: rtl/oldland_mem_branch.sv
// Memory/branch stage: executes loads/stores over a single-request data bus
// and resolves branches, releasing the fetch stall with a one-cycle pulse.
module oldland_mem_branch #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    input  logic        i_is_load,
    input  logic        i_is_store,
    input  logic        i_is_branch,
    input  logic        i_cond_met,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wr_data,
    input  logic [1:0]  i_width,
    input  logic [2:0]  i_rd,
    output logic        d_access,
    output logic        d_wr_en,
    output logic [31:0] d_addr,
    output logic [3:0]  d_bytesel,
    output logic [31:0] d_wr_data,
    input  logic        d_ack,
    input  logic [31:0] d_data,
    output logic        stall_clear,
    output logic        branch_taken,
    output logic [31:0] branch_pc,
    output logic        wb_valid,
    output logic [2:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        bus_error
);

    // state  | meaning
    // IDLE   | accepting execute-stage results, branches/misaligns resolved here
    // ACCESS | bus request outstanding, waiting for d_ack or timeout
    // DONE   | access finished, stall released this cycle
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam int CNT_W = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_q, load_d;
    logic [1:0]       width_q, width_d;
    logic [1:0]       lane_q, lane_d;
    logic [2:0]       rd_q, rd_d;

    logic        d_access_d, d_wr_en_d, stall_clear_d, branch_taken_d;
    logic        wb_valid_d, bus_error_d;
    logic [31:0] d_addr_d, d_wr_data_d, branch_pc_d, wb_data_d;
    logic [3:0]  d_bytesel_d;
    logic [2:0]  wb_rd_d;

    logic        misalign;
    logic [3:0]  req_bytesel;
    logic [31:0] req_wr_data;
    logic [31:0] rd_shifted;
    logic [31:0] load_data;

    always_comb begin
        misalign    = 1'b0;
        req_bytesel = 4'b1111;
        req_wr_data = i_wr_data;
        case (i_width)
            2'b00: begin
                req_bytesel = 4'b0001 << i_addr[1:0];
                req_wr_data = {4{i_wr_data[7:0]}};
            end
            2'b01: begin
                misalign    = i_addr[0];
                req_bytesel = i_addr[1] ? 4'b1100 : 4'b0011;
                req_wr_data = {2{i_wr_data[15:0]}};
            end
            default: misalign = (i_addr[1:0] != 2'b00);
        endcase
    end

    always_comb begin
        rd_shifted = d_data >> {lane_q, 3'b000};
        case (width_q)
            2'b00:   load_data = {24'h0, rd_shifted[7:0]};
            2'b01:   load_data = {16'h0, rd_shifted[15:0]};
            default: load_data = rd_shifted;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        load_d         = load_q;
        width_d        = width_q;
        lane_d         = lane_q;
        rd_d           = rd_q;
        d_access_d     = 1'b0;
        d_wr_en_d      = 1'b0;
        d_addr_d       = d_addr;
        d_bytesel_d    = d_bytesel;
        d_wr_data_d    = d_wr_data;
        stall_clear_d  = 1'b0;
        branch_taken_d = 1'b0;
        branch_pc_d    = branch_pc;
        wb_valid_d     = 1'b0;
        wb_rd_d        = wb_rd;
        wb_data_d      = wb_data;
        bus_error_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_valid && i_is_branch) begin
                    stall_clear_d  = 1'b1;
                    branch_taken_d = i_cond_met;
                    branch_pc_d    = i_addr;
                end else if (i_valid && (i_is_load || i_is_store)) begin
                    if (misalign) begin
                        stall_clear_d = 1'b1;
                        bus_error_d   = 1'b1;
                    end else begin
                        state_d     = ACCESS;
                        cnt_d       = '0;
                        d_access_d  = 1'b1;
                        d_wr_en_d   = i_is_store;
                        d_addr_d    = {i_addr[31:2], 2'b00};
                        d_bytesel_d = req_bytesel;
                        d_wr_data_d = req_wr_data;
                        load_d      = i_is_load;
                        width_d     = i_width;
                        lane_d      = i_addr[1:0];
                        rd_d        = i_rd;
                    end
                end
            end
            ACCESS: begin
                if (d_ack) begin
                    state_d       = DONE;
                    stall_clear_d = 1'b1;
                    if (load_q) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_data_d  = load_data;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = DONE;
                    stall_clear_d = 1'b1;
                    bus_error_d   = 1'b1;
                end else begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    d_access_d = 1'b1;
                    d_wr_en_d  = d_wr_en;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            load_q       <= 1'b0;
            width_q      <= 2'b00;
            lane_q       <= 2'b00;
            rd_q         <= 3'd0;
            d_access     <= 1'b0;
            d_wr_en      <= 1'b0;
            d_addr       <= 32'h0;
            d_bytesel    <= 4'h0;
            d_wr_data    <= 32'h0;
            stall_clear  <= 1'b0;
            branch_taken <= 1'b0;
            branch_pc    <= 32'h0;
            wb_valid     <= 1'b0;
            wb_rd        <= 3'd0;
            wb_data      <= 32'h0;
            bus_error    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            load_q       <= load_d;
            width_q      <= width_d;
            lane_q       <= lane_d;
            rd_q         <= rd_d;
            d_access     <= d_access_d;
            d_wr_en      <= d_wr_en_d;
            d_addr       <= d_addr_d;
            d_bytesel    <= d_bytesel_d;
            d_wr_data    <= d_wr_data_d;
            stall_clear  <= stall_clear_d;
            branch_taken <= branch_taken_d;
            branch_pc    <= branch_pc_d;
            wb_valid     <= wb_valid_d;
            wb_rd        <= wb_rd_d;
            wb_data      <= wb_data_d;
            bus_error    <= bus_error_d;
        end
    end

endmodule

// File: tb/tb_oldland_mem_branch.sv
// Bench for oldland_mem_branch: vector table drives operations, a queue of
// expected stall-release results is checked by a monitor on the falling edge.
module tb_oldland_mem_branch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid, i_is_load, i_is_store, i_is_branch, i_cond_met;
    logic [31:0] i_addr, i_wr_data;
    logic [1:0]  i_width;
    logic [2:0]  i_rd;
    logic        d_access, d_wr_en;
    logic [31:0] d_addr, d_wr_data;
    logic [3:0]  d_bytesel;
    logic        d_ack;
    logic [31:0] d_data;
    logic        stall_clear, branch_taken;
    logic [31:0] branch_pc;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [31:0] wb_data;
    logic        bus_error;

    oldland_mem_branch #(.BUS_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .i_is_load(i_is_load), .i_is_store(i_is_store),
        .i_is_branch(i_is_branch), .i_cond_met(i_cond_met),
        .i_addr(i_addr), .i_wr_data(i_wr_data), .i_width(i_width), .i_rd(i_rd),
        .d_access(d_access), .d_wr_en(d_wr_en), .d_addr(d_addr),
        .d_bytesel(d_bytesel), .d_wr_data(d_wr_data),
        .d_ack(d_ack), .d_data(d_data),
        .stall_clear(stall_clear), .branch_taken(branch_taken), .branch_pc(branch_pc),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld, st, br, cond;
        logic [31:0] addr, wdata;
        logic [1:0]  width;
        logic [2:0]  rd;
        int          delay;
        logic [31:0] rdata;
        logic        e_acc;
        logic [31:0] e_addr;
        logic [3:0]  e_sel;
        logic [31:0] e_wdata;
        logic        e_sc, e_taken;
        logic [31:0] e_pc;
        logic        e_wb;
        logic [31:0] e_wbdata;
        logic        e_err;
    } vec_t;

    typedef struct {
        logic        taken;
        logic [31:0] pc;
        logic        wb;
        logic [2:0]  rd;
        logic [31:0] wbdata;
        logic        err;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("pulse_without_stall_clear",
                32'((branch_taken | wb_valid | bus_error) & ~stall_clear), 32'h0);
            if (stall_clear === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_stall_clear: got stall_clear=1 expected 0 at %0t", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("branch_taken", 32'(branch_taken), 32'(mon_e.taken));
                    chk("bus_error", 32'(bus_error), 32'(mon_e.err));
                    chk("wb_valid", 32'(wb_valid), 32'(mon_e.wb));
                    if (mon_e.taken) chk("branch_pc", branch_pc, mon_e.pc);
                    if (mon_e.wb) begin
                        chk("wb_rd", 32'(wb_rd), 32'(mon_e.rd));
                        chk("wb_data", wb_data, mon_e.wbdata);
                    end
                end
            end
        end
    end

    task automatic drive_op(input vec_t v);
        i_valid     = 1'b1;
        i_is_load   = v.ld;
        i_is_store  = v.st;
        i_is_branch = v.br;
        i_cond_met  = v.cond;
        i_addr      = v.addr;
        i_wr_data   = v.wdata;
        i_width     = v.width;
        i_rd        = v.rd;
        if (v.e_sc) exp_q.push_back('{v.e_taken, v.e_pc, v.e_wb, v.rd, v.e_wbdata, v.e_err});
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        @(posedge clk); #1;
        drive_op(v);
        @(posedge clk); #1;
        i_valid = 1'b0;
        chk($sformatf("v%0d_d_access", idx), 32'(d_access), 32'(v.e_acc));
        if (v.e_acc) begin
            chk($sformatf("v%0d_d_addr", idx), d_addr, v.e_addr);
            chk($sformatf("v%0d_d_bytesel", idx), 32'(d_bytesel), 32'(v.e_sel));
            chk($sformatf("v%0d_d_wr_en", idx), 32'(d_wr_en), 32'(v.st));
            if (v.st) chk($sformatf("v%0d_d_wr_data", idx), d_wr_data, v.e_wdata);
            for (int i = 0; i < v.delay; i++) begin
                @(posedge clk); #1;
                chk($sformatf("v%0d_hold_access", idx), 32'(d_access), 32'h1);
                chk($sformatf("v%0d_hold_addr", idx), d_addr, v.e_addr);
                chk($sformatf("v%0d_hold_bytesel", idx), 32'(d_bytesel), 32'(v.e_sel));
            end
            d_ack  = 1'b1;
            d_data = v.rdata;
            @(posedge clk); #1;
            d_ack = 1'b0;
            chk($sformatf("v%0d_access_drop", idx), 32'(d_access), 32'h0);
        end
        @(posedge clk); #1;
        chk($sformatf("v%0d_drained", idx), 32'(exp_q.size()), 32'h0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   n;
        // ld st br cond addr wdata width rd delay rdata | e_acc e_addr e_sel e_wdata e_sc e_taken e_pc e_wb e_wbdata e_err
        vecs[0]  = '{0,0,1,1, 32'h100, 32'h0, 2'b10, 3'd0, 0, 32'h0,         0, 32'h0, 4'h0, 32'h0,         1,1, 32'h100, 0, 32'h0, 0};
        vecs[1]  = '{0,0,1,0, 32'h200, 32'h0, 2'b10, 3'd0, 0, 32'h0,         0, 32'h0, 4'h0, 32'h0,         1,0, 32'h200, 0, 32'h0, 0};
        vecs[2]  = '{1,0,0,0, 32'h1003, 32'h0, 2'b00, 3'd5, 3, 32'hAABBCCDD, 1, 32'h1000, 4'b1000, 32'h0,    1,0, 32'h0, 1, 32'hAA, 0};
        vecs[3]  = '{0,1,0,0, 32'h2002, 32'hFFFF1234, 2'b01, 3'd0, 0, 32'h0, 1, 32'h2000, 4'b1100, 32'h12341234, 1,0, 32'h0, 0, 32'h0, 0};
        vecs[4]  = '{1,0,0,0, 32'h3001, 32'h0, 2'b10, 3'd3, 0, 32'h0,        0, 32'h0, 4'h0, 32'h0,         1,0, 32'h0, 0, 32'h0, 1};
        vecs[5]  = '{1,0,0,0, 32'h4000, 32'h0, 2'b01, 3'd2, 1, 32'h89ABCDEF, 1, 32'h4000, 4'b0011, 32'h0,    1,0, 32'h0, 1, 32'hCDEF, 0};
        vecs[6]  = '{1,0,0,0, 32'h4002, 32'h0, 2'b01, 3'd7, 0, 32'h89ABCDEF, 1, 32'h4000, 4'b1100, 32'h0,    1,0, 32'h0, 1, 32'h89AB, 0};
        vecs[7]  = '{1,0,0,0, 32'h5000, 32'h0, 2'b11, 3'd1, 2, 32'hDEADBEEF, 1, 32'h5000, 4'b1111, 32'h0,    1,0, 32'h0, 1, 32'hDEADBEEF, 0};
        vecs[8]  = '{0,1,0,0, 32'h6001, 32'h123456A5, 2'b00, 3'd0, 0, 32'h0, 1, 32'h6000, 4'b0010, 32'hA5A5A5A5, 1,0, 32'h0, 0, 32'h0, 0};
        vecs[9]  = '{0,1,0,0, 32'h7004, 32'h0BADF00D, 2'b10, 3'd0, 1, 32'h0, 1, 32'h7004, 4'b1111, 32'h0BADF00D, 1,0, 32'h0, 0, 32'h0, 0};
        vecs[10] = '{0,1,0,0, 32'h8001, 32'h1, 2'b01, 3'd0, 0, 32'h0,        0, 32'h0, 4'h0, 32'h0,         1,0, 32'h0, 0, 32'h0, 1};
        vecs[11] = '{0,0,0,1, 32'h9000, 32'h0, 2'b10, 3'd4, 0, 32'h0,        0, 32'h0, 4'h0, 32'h0,         0,0, 32'h0, 0, 32'h0, 0};
        vecs[12] = '{1,0,0,0, 32'h9001, 32'h0, 2'b00, 3'd6, 0, 32'h11223344, 1, 32'h9000, 4'b0010, 32'h0,    1,0, 32'h0, 1, 32'h33, 0};
        vecs[13] = '{1,0,0,0, 32'h4003, 32'h0, 2'b01, 3'd0, 0, 32'h0,        0, 32'h0, 4'h0, 32'h0,         1,0, 32'h0, 0, 32'h0, 1};
        vecs[14] = '{0,1,0,0, 32'hA002, 32'h5, 2'b10, 3'd0, 0, 32'h0,        0, 32'h0, 4'h0, 32'h0,         1,0, 32'h0, 0, 32'h0, 1};

        rst_n = 1'b0;
        i_valid = 0; i_is_load = 0; i_is_store = 0; i_is_branch = 0; i_cond_met = 0;
        i_addr = 0; i_wr_data = 0; i_width = 0; i_rd = 0; d_ack = 0; d_data = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_d_access", 32'(d_access), 32'h0);
        chk("reset_stall_clear", 32'(stall_clear), 32'h0);
        chk("reset_outputs", {d_addr[31:4] | d_wr_data[31:4] | branch_pc[31:4] | wb_data[31:4],
                              d_bytesel | {d_wr_en, wb_valid, bus_error, branch_taken}}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

        // Timeout: no ack, then a late ack that must be ignored
        v = vecs[7];
        v.delay = 0; v.e_wb = 0; v.e_err = 1; v.addr = 32'h100;
        @(posedge clk); #1;
        drive_op(v);
        @(posedge clk); #1;
        i_valid = 1'b0;
        n = 0;
        while (d_access === 1'b1 && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        chk("timeout_access_cycles", 32'(n), 32'd4);
        d_ack = 1'b1;
        @(posedge clk); #1;
        chk("late_ack_no_access", 32'(d_access), 32'h0);
        @(posedge clk); #1;
        d_ack = 1'b0;
        chk("late_ack_no_access2", 32'(d_access), 32'h0);
        chk("timeout_drained", 32'(exp_q.size()), 32'h0);
        exp_q.delete();

        // New i_valid during DONE is dropped
        v = vecs[2];
        v.addr = 32'h1000; v.rd = 3'd4; v.e_wbdata = 32'h5A;
        @(posedge clk); #1;
        drive_op(v);
        @(posedge clk); #1;
        i_valid = 1'b0;
        d_ack = 1'b1; d_data = 32'h0000005A;
        @(posedge clk); #1;
        d_ack = 1'b0;
        i_valid = 1'b1; i_is_load = 0; i_is_branch = 1; i_cond_met = 1; i_addr = 32'hDEAD0000;
        @(posedge clk); #1;
        i_valid = 1'b0; i_is_branch = 0;
        chk("done_valid_ignored", 32'(stall_clear), 32'h0);
        @(posedge clk); #1;
        chk("done_drained", 32'(exp_q.size()), 32'h0);
        exp_q.delete();

        // Reset mid-access, ack during/after reset ignored, then a branch
        v = vecs[7];
        v.e_sc = 0;
        @(posedge clk); #1;
        drive_op(v);
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_reset_access", 32'(d_access), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("reset_async_access", 32'(d_access), 32'h0);
        d_ack = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        v = vecs[0];
        v.addr = 32'h300; v.e_pc = 32'h300;
        drive_op(v);
        @(posedge clk); #1;
        i_valid = 1'b0;
        chk("post_reset_no_access", 32'(d_access), 32'h0);
        @(posedge clk); #1;
        d_ack = 1'b0;
        chk("post_reset_drained", 32'(exp_q.size()), 32'h0);
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
